// File: rtl/alu_exec_unit.sv
// RV32I integer execute unit: combinational compute, DEPTH-entry result queue, CDB broadcast of head.
// Latency: launch sampled at edge N -> is_alu_ok in cycle N+1 when queue empty; head held until granted.
// Backpressure: alu_busy at count >= DEPTH-2 so the one launch already in flight never overflows.

module alu_result_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && (count != '0);
   // A pop on the same edge frees the slot, so push is legal even when full.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
         if (push && !do_push) ovf <= 1'b1;
      end
   end
endmodule

module alu_exec_unit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        work_en,
   input  logic [3:0]  rob_id_from_rs,
   input  logic [5:0]  opcode_from_rs,
   input  logic [31:0] val1,
   input  logic [31:0] val2,
   input  logic [31:0] imm_from_rs,
   input  logic [31:0] pc_from_rs,
   output logic        alu_busy,
   input  logic        res_grant,
   output logic        is_alu_ok,
   output logic [3:0]  rob_id_from_alu,
   output logic [31:0] res_from_alu,
   output logic        alu_jump,
   output logic [31:0] alu_target,
   output logic        alu_ovf
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = 4 + 32 + 1 + 32;

   localparam logic [5:0] OP_LUI   = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL   = 6'd2,  OP_JALR  = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE   = 6'd5,  OP_BLT   = 6'd6,  OP_BGE   = 6'd7;
   localparam logic [5:0] OP_BLTU  = 6'd8,  OP_BGEU  = 6'd9;
   localparam logic [5:0] OP_ADDI  = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI  = 6'd13;
   localparam logic [5:0] OP_ORI   = 6'd14, OP_ANDI  = 6'd15, OP_SLLI  = 6'd16, OP_SRLI  = 6'd17;
   localparam logic [5:0] OP_SRAI  = 6'd18;
   localparam logic [5:0] OP_ADD   = 6'd19, OP_SUB   = 6'd20, OP_SLL   = 6'd21, OP_SLT   = 6'd22;
   localparam logic [5:0] OP_SLTU  = 6'd23, OP_XOR   = 6'd24, OP_SRL   = 6'd25, OP_SRA   = 6'd26;
   localparam logic [5:0] OP_OR    = 6'd27, OP_AND   = 6'd28;

   logic          is_itype;
   logic [31:0]   op2;
   logic [4:0]    shamt;
   logic          lt_s;
   logic          lt_u;
   logic          eq;
   logic          taken;
   logic [31:0]   pc_4;
   logic [31:0]   pc_imm;
   logic [31:0]   result;
   logic          jump;
   logic [31:0]   target;

   logic          push;
   logic          pop;
   logic [EW-1:0] head;
   logic [CW-1:0] count;

   always_comb begin
      is_itype = (opcode_from_rs >= OP_ADDI) && (opcode_from_rs <= OP_SRAI);
      op2      = is_itype ? imm_from_rs : val2;
      shamt    = op2[4:0];
      lt_s     = $signed(val1) < $signed(op2);
      lt_u     = val1 < op2;
      eq       = (val1 == op2);
      pc_4     = pc_from_rs + 32'd4;
      pc_imm   = pc_from_rs + imm_from_rs;
      result   = '0;
      jump     = 1'b0;
      target   = pc_4;
      taken    = 1'b0;
      case (opcode_from_rs)
         OP_LUI:            result = imm_from_rs;
         OP_AUIPC:          result = pc_imm;
         OP_JAL: begin
            result = pc_4;
            jump   = 1'b1;
            target = pc_imm;
         end
         OP_JALR: begin
            result = pc_4;
            jump   = 1'b1;
            target = (val1 + imm_from_rs) & ~32'd1;
         end
         OP_BEQ:            taken = eq;
         OP_BNE:            taken = !eq;
         OP_BLT:            taken = lt_s;
         OP_BGE:            taken = !lt_s;
         OP_BLTU:           taken = lt_u;
         OP_BGEU:           taken = !lt_u;
         OP_ADDI, OP_ADD:   result = val1 + op2;
         OP_SUB:            result = val1 - op2;
         OP_SLTI, OP_SLT:   result = {31'd0, lt_s};
         OP_SLTIU, OP_SLTU: result = {31'd0, lt_u};
         OP_XORI, OP_XOR:   result = val1 ^ op2;
         OP_ORI, OP_OR:     result = val1 | op2;
         OP_ANDI, OP_AND:   result = val1 & op2;
         OP_SLLI, OP_SLL:   result = val1 << shamt;
         OP_SRLI, OP_SRL:   result = val1 >> shamt;
         OP_SRAI, OP_SRA:   result = 32'($signed(val1) >>> shamt);
         default:           result = '0;
      endcase
      if (taken) begin
         jump   = 1'b1;
         target = pc_imm;
      end
   end

   // rdy gates queue movement; clear goes straight through so a flush lands even when frozen.
   assign push      = rdy && work_en && !clear;
   assign is_alu_ok = rdy && (count != '0);
   assign pop       = is_alu_ok && res_grant;
   assign alu_busy  = (count >= CW'(DEPTH - 2));

   alu_result_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .din   ({rob_id_from_rs, result, jump, target}),
      .dout  (head),
      .count (count),
      .ovf   (alu_ovf)
   );

   assign {rob_id_from_alu, res_from_alu, alu_jump, alu_target} = head;
endmodule
